// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signal bundle for the direct-mapped instruction cache.
// The slave modport is the cache's own view; master is the surrounding datapath/memory side.
interface icache_direct_if;
  logic        dp_imemREN;
  logic [31:0] dp_imemaddr;
  logic        dp_ihit;
  logic [31:0] dp_imemload;
  logic        ram_iREN;
  logic [31:0] ram_iaddr;
  logic        ram_iwait;
  logic [31:0] ram_iload;
  logic        flush;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  modport slave (
    input  dp_imemREN, dp_imemaddr, ram_iwait, ram_iload, flush,
    output dp_ihit, dp_imemload, ram_iREN, ram_iaddr, hit_cnt, miss_cnt
  );

  modport master (
    output dp_imemREN, dp_imemaddr, ram_iwait, ram_iload, flush,
    input  dp_ihit, dp_imemload, ram_iREN, ram_iaddr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache with single-word miss fill,
// same-cycle forwarding of the fill word, whole-cache flush and hit/miss counters.
module icache_direct #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input logic            CLK,
  input logic            RST,
  icache_direct_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t             state_r;
  state_t             next_state_s;

  logic [SETS-1:0]    valid_r;
  logic [TAG_W-1:0]   tag_r  [SETS];
  logic [31:0]        data_r [SETS];

  logic [31:0]        maddr_r;
  logic [31:0]        hit_cnt_r;
  logic [31:0]        miss_cnt_r;

  logic [31:0]        addr_word_s;
  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [IDX_W-1:0]   midx_s;
  logic [TAG_W-1:0]   mtag_s;
  logic               lookup_hit_s;

  logic               ihit_s;
  logic [31:0]        iload_s;
  logic               ren_s;
  logic [31:0]        iaddr_s;
  logic               fill_s;
  logic               hit_inc_s;
  logic               miss_inc_s;

  // Byte offset is dropped by masking so the full word address can be compared and latched.
  assign addr_word_s  = bus.dp_imemaddr & 32'hFFFF_FFFC;
  assign idx_s        = addr_word_s[IDX_W+1:2];
  assign tag_s        = addr_word_s[31:IDX_W+2];
  assign midx_s       = maddr_r[IDX_W+1:2];
  assign mtag_s       = maddr_r[31:IDX_W+2];
  assign lookup_hit_s = bus.dp_imemREN & valid_r[idx_s] & (tag_r[idx_s] == tag_s);

  // Next-state, fetch-side response and fill request; everything held quiet during reset.
  always_comb begin
    next_state_s = state_r;
    ihit_s       = 1'b0;
    iload_s      = 32'h0000_0000;
    ren_s        = 1'b0;
    iaddr_s      = 32'h0000_0000;
    fill_s       = 1'b0;
    hit_inc_s    = 1'b0;
    miss_inc_s   = 1'b0;
    if (RST) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (lookup_hit_s) begin
            ihit_s    = 1'b1;
            iload_s   = data_r[idx_s];
            hit_inc_s = 1'b1;
          end else if (bus.dp_imemREN) begin
            miss_inc_s   = 1'b1;
            next_state_s = FETCH;
          end else begin
            next_state_s = IDLE;
          end
        end
        FETCH: begin
          ren_s   = 1'b1;
          iaddr_s = maddr_r;
          if (!bus.ram_iwait) begin
            fill_s       = 1'b1;
            next_state_s = IDLE;
            // Forward only if the datapath still wants the word being filled.
            if (bus.dp_imemREN && (addr_word_s == maddr_r)) begin
              ihit_s  = 1'b1;
              iload_s = bus.ram_iload;
            end else begin
              ihit_s  = 1'b0;
              iload_s = 32'h0000_0000;
            end
          end else begin
            next_state_s = FETCH;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  // Control state: FSM, valid bits, latched miss address and performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      valid_r    <= '0;
      maddr_r    <= 32'h0000_0000;
      hit_cnt_r  <= 32'h0000_0000;
      miss_cnt_r <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      // Flush beats a coincident fill so the line ends up invalid.
      if (bus.flush) begin
        valid_r <= '0;
      end else if (fill_s) begin
        valid_r[midx_s] <= 1'b1;
      end else begin
        valid_r <= valid_r;
      end
      if (hit_inc_s) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end else begin
        hit_cnt_r <= hit_cnt_r;
      end
      if (miss_inc_s) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
        maddr_r    <= addr_word_s;
      end else begin
        miss_cnt_r <= miss_cnt_r;
        maddr_r    <= maddr_r;
      end
    end
  end

  // Tag/data storage has no reset; fill_s is already suppressed while RST is high.
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      data_r[midx_s] <= bus.ram_iload;
      tag_r[midx_s]  <= mtag_s;
    end
  end

  assign bus.dp_ihit     = ihit_s;
  assign bus.dp_imemload = iload_s;
  assign bus.ram_iREN    = ren_s;
  assign bus.ram_iaddr   = iaddr_s;
  assign bus.hit_cnt     = hit_cnt_r;
  assign bus.miss_cnt    = miss_cnt_r;

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct: inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_icache_direct;
  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  icache_direct_if ifc ();

  icache_direct #(.SETS(16), .IDX_W(4), .TAG_W(26)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Miss-and-fill of one address: one IDLE miss cycle, `waits` busy cycles, one data cycle.
  task automatic do_fill(input logic [31:0] a, input int waits, input logic [31:0] d);
    ifc.dp_imemREN  = 1'b1;
    ifc.dp_imemaddr = a;
    ifc.ram_iwait   = 1'b1;
    next_cycle();
    repeat (waits) next_cycle();
    ifc.ram_iwait = 1'b0;
    ifc.ram_iload = d;
    next_cycle();
    ifc.dp_imemREN = 1'b0;
    ifc.ram_iwait  = 1'b1;
    ifc.ram_iload  = 32'h0000_0000;
  endtask

  task automatic test_reset();
    ifc.dp_imemREN  = 1'b1;
    ifc.dp_imemaddr = 32'h0000_0040;
    ifc.ram_iwait   = 1'b0;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got %0b want 0", ifc.dp_ihit); end
    checks++; if (ifc.ram_iREN !== 1'b0) begin errors++; $display("FAIL reset_iren got %0b want 0", ifc.ram_iREN); end
    checks++; if (ifc.ram_iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr got %h want 0", ifc.ram_iaddr); end
    checks++; if (ifc.hit_cnt !== 32'd0 || ifc.miss_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", ifc.hit_cnt, ifc.miss_cnt); end
    next_cycle();
    RST = 1'b0;
    ifc.dp_imemREN = 1'b0;
    ifc.ram_iwait  = 1'b1;
  endtask

  task automatic test_cold_miss();
    ifc.dp_imemREN  = 1'b1;
    ifc.dp_imemaddr = 32'h0000_0040;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b0 || ifc.ram_iREN !== 1'b0) begin errors++; $display("FAIL cold_idle got ihit=%0b iren=%0b want 0/0", ifc.dp_ihit, ifc.ram_iREN); end
    next_cycle();
    checks++; if (ifc.miss_cnt !== 32'd1) begin errors++; $display("FAIL cold_miss_cnt got %0d want 1", ifc.miss_cnt); end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++; if (ifc.ram_iREN !== 1'b1 || ifc.ram_iaddr !== 32'h40 || ifc.dp_ihit !== 1'b0) begin errors++; $display("FAIL cold_wait%0d got iren=%0b iaddr=%h ihit=%0b want 1/40/0", i, ifc.ram_iREN, ifc.ram_iaddr, ifc.dp_ihit); end
      next_cycle();
    end
    ifc.ram_iwait = 1'b0;
    ifc.ram_iload = 32'h8C22_0004;
    @(negedge CLK);
    checks++; if (ifc.ram_iREN !== 1'b1 || ifc.dp_ihit !== 1'b1 || ifc.dp_imemload !== 32'h8C22_0004) begin errors++; $display("FAIL cold_fwd got iren=%0b ihit=%0b load=%h want 1/1/8c220004", ifc.ram_iREN, ifc.dp_ihit, ifc.dp_imemload); end
    next_cycle();
    ifc.dp_imemREN = 1'b0;
    ifc.ram_iwait  = 1'b1;
    ifc.ram_iload  = 32'h0000_0000;
    @(negedge CLK);
    checks++; if (ifc.ram_iREN !== 1'b0 || ifc.hit_cnt !== 32'd0) begin errors++; $display("FAIL cold_after got iren=%0b hit_cnt=%0d want 0/0", ifc.ram_iREN, ifc.hit_cnt); end
    next_cycle();
  endtask

  task automatic test_warm_hit();
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_0040;
    addrs[1] = 32'h0000_0043;
    for (int i = 0; i < 2; i++) begin
      ifc.dp_imemREN  = 1'b1;
      ifc.dp_imemaddr = addrs[i];
      @(negedge CLK);
      checks++; if (ifc.dp_ihit !== 1'b1 || ifc.dp_imemload !== 32'h8C22_0004 || ifc.ram_iREN !== 1'b0) begin errors++; $display("FAIL warm_hit%0d got ihit=%0b load=%h iren=%0b want 1/8c220004/0", i, ifc.dp_ihit, ifc.dp_imemload, ifc.ram_iREN); end
      next_cycle();
      checks++; if (ifc.hit_cnt !== 32'(i + 1)) begin errors++; $display("FAIL warm_hit_cnt%0d got %0d want %0d", i, ifc.hit_cnt, i + 1); end
    end
    ifc.dp_imemREN = 1'b0;
  endtask

  task automatic test_conflict();
    ifc.dp_imemREN  = 1'b1;
    ifc.dp_imemaddr = 32'h0000_0080;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b0) begin errors++; $display("FAIL conflict_80 got ihit=%0b want 0", ifc.dp_ihit); end
    do_fill(32'h0000_0080, 1, 32'h1111_1111);
    ifc.dp_imemREN  = 1'b1;
    ifc.dp_imemaddr = 32'h0000_0040;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b0) begin errors++; $display("FAIL conflict_40 got ihit=%0b want 0", ifc.dp_ihit); end
    do_fill(32'h0000_0040, 0, 32'h8C22_0004);
    checks++; if (ifc.miss_cnt !== 32'd3) begin errors++; $display("FAIL conflict_miss_cnt got %0d want 3", ifc.miss_cnt); end
    ifc.dp_imemREN  = 1'b1;
    ifc.dp_imemaddr = 32'h0000_0040;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b1 || ifc.dp_imemload !== 32'h8C22_0004) begin errors++; $display("FAIL conflict_rehit got ihit=%0b load=%h want 1/8c220004", ifc.dp_ihit, ifc.dp_imemload); end
    next_cycle();
    ifc.dp_imemREN = 1'b0;
  endtask

  task automatic test_addr_change();
    ifc.dp_imemREN  = 1'b1;
    ifc.dp_imemaddr = 32'h0000_0100;
    next_cycle();
    ifc.dp_imemaddr = 32'h0000_0104;
    next_cycle();
    ifc.ram_iwait = 1'b0;
    ifc.ram_iload = 32'hAAAA_5555;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b0 || ifc.ram_iREN !== 1'b1 || ifc.ram_iaddr !== 32'h100) begin errors++; $display("FAIL chg_fill got ihit=%0b iren=%0b iaddr=%h want 0/1/100", ifc.dp_ihit, ifc.ram_iREN, ifc.ram_iaddr); end
    next_cycle();
    ifc.ram_iwait   = 1'b1;
    ifc.ram_iload   = 32'h0000_0000;
    ifc.dp_imemaddr = 32'h0000_0100;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b1 || ifc.dp_imemload !== 32'hAAAA_5555) begin errors++; $display("FAIL chg_line100 got ihit=%0b load=%h want 1/aaaa5555", ifc.dp_ihit, ifc.dp_imemload); end
    next_cycle();
    ifc.dp_imemaddr = 32'h0000_0104;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b0) begin errors++; $display("FAIL chg_104_miss got ihit=%0b want 0", ifc.dp_ihit); end
    next_cycle();
    @(negedge CLK);
    checks++; if (ifc.ram_iREN !== 1'b1 || ifc.ram_iaddr !== 32'h104) begin errors++; $display("FAIL chg_104_req got iren=%0b iaddr=%h want 1/104", ifc.ram_iREN, ifc.ram_iaddr); end
    ifc.ram_iwait = 1'b0;
    ifc.ram_iload = 32'h2222_2222;
    next_cycle();
    ifc.dp_imemREN = 1'b0;
    ifc.ram_iwait  = 1'b1;
    checks++; if (ifc.miss_cnt !== 32'd5 || ifc.hit_cnt !== 32'd4) begin errors++; $display("FAIL chg_cnt got miss=%0d hit=%0d want 5/4", ifc.miss_cnt, ifc.hit_cnt); end
  endtask

  task automatic test_flush_fill();
    ifc.dp_imemREN  = 1'b1;
    ifc.dp_imemaddr = 32'h0000_0200;
    next_cycle();
    next_cycle();
    ifc.ram_iwait = 1'b0;
    ifc.ram_iload = 32'hDEAD_BEEF;
    ifc.flush     = 1'b1;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b1 || ifc.dp_imemload !== 32'hDEAD_BEEF) begin errors++; $display("FAIL flush_fwd got ihit=%0b load=%h want 1/deadbeef", ifc.dp_ihit, ifc.dp_imemload); end
    next_cycle();
    ifc.flush     = 1'b0;
    ifc.ram_iwait = 1'b1;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b0) begin errors++; $display("FAIL flush_200_miss got ihit=%0b want 0", ifc.dp_ihit); end
    next_cycle();
    checks++; if (ifc.miss_cnt !== 32'd7) begin errors++; $display("FAIL flush_miss_cnt got %0d want 7", ifc.miss_cnt); end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge CLK);
    checks++; if (ifc.ram_iREN !== 1'b1) begin errors++; $display("FAIL rstf_pre got iren=%0b want 1", ifc.ram_iREN); end
    next_cycle();
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (ifc.ram_iREN !== 1'b0 || ifc.ram_iaddr !== 32'h0) begin errors++; $display("FAIL rstf_during got iren=%0b iaddr=%h want 0/0", ifc.ram_iREN, ifc.ram_iaddr); end
    next_cycle();
    RST = 1'b0;
    ifc.dp_imemREN = 1'b0;
    @(negedge CLK);
    checks++; if (ifc.ram_iREN !== 1'b0 || ifc.hit_cnt !== 32'd0 || ifc.miss_cnt !== 32'd0) begin errors++; $display("FAIL rstf_after got iren=%0b hit=%0d miss=%0d want 0/0/0", ifc.ram_iREN, ifc.hit_cnt, ifc.miss_cnt); end
    ifc.dp_imemREN  = 1'b1;
    ifc.dp_imemaddr = 32'h0000_0040;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b0) begin errors++; $display("FAIL rstf_40_miss got ihit=%0b want 0", ifc.dp_ihit); end
    do_fill(32'h0000_0040, 0, 32'h8C22_0004);
  endtask

  task automatic test_flush_idle();
    ifc.dp_imemREN  = 1'b1;
    ifc.dp_imemaddr = 32'h0000_0040;
    ifc.flush       = 1'b1;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b1 || ifc.dp_imemload !== 32'h8C22_0004) begin errors++; $display("FAIL flushidle_pre got ihit=%0b load=%h want 1/8c220004", ifc.dp_ihit, ifc.dp_imemload); end
    next_cycle();
    ifc.flush = 1'b0;
    @(negedge CLK);
    checks++; if (ifc.dp_ihit !== 1'b0 || ifc.hit_cnt !== 32'd1) begin errors++; $display("FAIL flushidle_post got ihit=%0b hit=%0d want 0/1", ifc.dp_ihit, ifc.hit_cnt); end
    next_cycle();
    ifc.dp_imemREN = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    RST             = 1'b1;
    ifc.dp_imemREN  = 1'b0;
    ifc.dp_imemaddr = 32'h0000_0000;
    ifc.ram_iwait   = 1'b1;
    ifc.ram_iload   = 32'h0000_0000;
    ifc.flush       = 1'b0;
    next_cycle();
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_addr_change();
    test_flush_fill();
    test_reset_mid_fetch();
    test_flush_idle();
    repeat (3) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
